// File: rtl/bank_access_arbiter.sv
// bank_access_arbiter: arbitrates two read and two write clients onto one dual-port feature-map bank.
// Optional macro RAW_BYPASS_EN forwards same-cycle same-address write data to the read return.
// Revision: 1.0
`default_nettype none

module bank_access_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  load_done,
  output logic                  busy_load,
  output logic [ADDR_WIDTH:0]   ld_count,
  output logic                  addr_err,
  input  logic                  ld_wr_req,
  input  logic [ADDR_WIDTH-1:0] ld_wr_addr,
  input  logic [DATA_WIDTH-1:0] ld_wr_data,
  output logic                  ld_wr_gnt,
  input  logic                  wb_wr_req,
  input  logic [ADDR_WIDTH-1:0] wb_wr_addr,
  input  logic [DATA_WIDTH-1:0] wb_wr_data,
  output logic                  wb_wr_gnt,
  input  logic                  rd0_req,
  input  logic [ADDR_WIDTH-1:0] rd0_addr,
  output logic                  rd0_gnt,
  output logic                  rd0_valid,
  output logic [DATA_WIDTH-1:0] rd0_data,
  input  logic                  rd1_req,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic                  rd1_gnt,
  output logic                  rd1_valid,
  output logic [DATA_WIDTH-1:0] rd1_data,
  output logic                  mem_csen,
  output logic                  mem_rdena,
  output logic [ADDR_WIDTH-1:0] mem_addr_a,
  input  logic [DATA_WIDTH-1:0] mem_data_a,
  output logic                  mem_wrenb,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  output logic [DATA_WIDTH-1:0] mem_data_b
);

  localparam logic [ADDR_WIDTH:0] DEPTH  = DATA_DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LD_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [0:0] {RUN = 1'b0, LOAD = 1'b1} mode_t;

  mode_t                 mode;
  logic                  rr;          // 0 selects rd0, 1 selects rd1
  logic                  ret0, ret1, ret_oor;
  logic                  run;
  logic                  rd_gnt, wr_gnt, rd_oor, wr_oor;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
  logic [DATA_WIDTH-1:0] wr_data, rd_word;

  always_comb begin
    run        = (mode == RUN);
    rd0_gnt    = run & rd0_req & (~rd1_req | ~rr);
    rd1_gnt    = run & rd1_req & (~rd0_req | rr);
    ld_wr_gnt  = ~run & ld_wr_req;
    wb_wr_gnt  = run & wb_wr_req;
    rd_gnt     = rd0_gnt | rd1_gnt;
    wr_gnt     = ld_wr_gnt | wb_wr_gnt;
    rd_addr    = rd1_gnt ? rd1_addr : rd0_addr;
    wr_addr    = ld_wr_gnt ? ld_wr_addr : wb_wr_addr;
    wr_data    = ld_wr_gnt ? ld_wr_data : wb_wr_data;
    rd_oor     = ({1'b0, rd_addr} >= DEPTH);
    wr_oor     = ({1'b0, wr_addr} >= DEPTH);
    // Out-of-range requests are granted but never reach the bank.
    mem_rdena  = rd_gnt & ~rd_oor;
    mem_wrenb  = wr_gnt & ~wr_oor;
    mem_csen   = mem_rdena | mem_wrenb;
    mem_addr_a = mem_rdena ? rd_addr : '0;
    mem_addr_b = mem_wrenb ? wr_addr : '0;
    mem_data_b = mem_wrenb ? wr_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= RUN;
      rr       <= 1'b0;
      ld_count <= '0;
      addr_err <= 1'b0;
      ret0     <= 1'b0;
      ret1     <= 1'b0;
      ret_oor  <= 1'b0;
    end else begin
      case (mode)
        RUN:  if (load_start) mode <= LOAD;
        LOAD: if (load_done)  mode <= RUN;
        default: mode <= RUN;
      endcase
      if (run && load_start)
        ld_count <= '0;
      else if (ld_wr_gnt && ld_count != LD_MAX)
        ld_count <= ld_count + 1'b1;
      if (rd0_gnt)
        rr <= 1'b1;
      else if (rd1_gnt)
        rr <= 1'b0;
      addr_err <= addr_err | (rd_gnt & rd_oor) | (wr_gnt & wr_oor);
      ret0     <= rd0_gnt;
      ret1     <= rd1_gnt;
      ret_oor  <= rd_gnt & rd_oor;
    end
  end

`ifdef RAW_BYPASS_EN
  logic                  byp_hit;
  logic [DATA_WIDTH-1:0] byp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_hit <= mem_rdena & mem_wrenb & (mem_addr_a == mem_addr_b);
      if (mem_rdena && mem_wrenb && mem_addr_a == mem_addr_b)
        byp_data <= mem_data_b;
    end
  end

  assign rd_word = ret_oor ? '0 : (byp_hit ? byp_data : mem_data_a);
`else
  assign rd_word = ret_oor ? '0 : mem_data_a;
`endif

  assign busy_load = (mode == LOAD);
  assign rd0_valid = ret0;
  assign rd1_valid = ret1;
  assign rd0_data  = ret0 ? rd_word : '0;
  assign rd1_data  = ret1 ? rd_word : '0;

endmodule

`default_nettype wire

// File: doc/bank_access_arbiter.md
# bank_access_arbiter

Shares one dual-port feature-map bank (read port A, write port B, 1-cycle registered read) between two read clients (conv engine, pool engine) and two write clients (SPI loader, result write-back). It sits directly in front of each bank instance and drives the bank's chip-select, read-enable, write-enable, address and write-data lines. A two-state mode machine gives the SPI loader exclusive access during image load. Read data returned by the bank is steered back to the client that issued the read.

## Interface
- ADDR_WIDTH, 13, bank address width
- DATA_WIDTH, 8, word width
- DATA_DEPTH, 1024, valid word count; addresses ≥ DATA_DEPTH are out of range
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- load_start / load_done  in  1 / 1  enter / leave LOAD mode (single-cycle pulses)
- busy_load  out  1  high while in LOAD
- ld_count  out  ADDR_WIDTH+1  loader words written since last LOAD entry
- addr_err  out  1  sticky out-of-range flag; cleared only by reset
- ld_wr_req, ld_wr_addr, ld_wr_data  in  1, ADDR_WIDTH, DATA_WIDTH  loader write request
- ld_wr_gnt  out  1  loader write accepted this cycle
- wb_wr_req, wb_wr_addr, wb_wr_data  in  1, ADDR_WIDTH, DATA_WIDTH  write-back request
- wb_wr_gnt  out  1  write-back accepted this cycle
- rdN_req, rdN_addr  in  1, ADDR_WIDTH  read request, N = 0, 1
- rdN_gnt  out  1  read accepted this cycle
- rdN_valid, rdN_data  out  1, DATA_WIDTH  read return
- mem_csen, mem_rdena, mem_addr_a  out  1, 1, ADDR_WIDTH  bank read side
- mem_data_a  in  DATA_WIDTH  bank read data (registered in bank, zero when not read)
- mem_wrenb, mem_addr_b, mem_data_b  out  1, ADDR_WIDTH, DATA_WIDTH  bank write side

## Operation
- Mode FSM: RUN (reset state), LOAD.
  - RUN→LOAD on load_start; load_done is ignored in RUN.
  - LOAD→RUN on load_done; load_start is ignored in LOAD.
  - load_start and load_done together in RUN: go to LOAD.
- LOAD:
  - Only ld_wr_req is granted.
  - rdN_gnt and wb_wr_gnt are forced to 0.
- RUN:
  - ld_wr_gnt is forced to 0.
  - wb_wr_req is granted whenever asserted.
- Reads (RUN only):
  - Round-robin pointer rr; reset value selects rd0.
  - Only one client requesting: that client is granted.
  - Both requesting: the client selected by rr is granted.
  - After any read grant, rr points to the non-granted client.
- A grant is a combinational function of req, mode and rr in the same cycle. A request is consumed on the cycle its gnt is high; the client holds req/addr/data until then.
- Memory drive (combinational from grants):
  - mem_rdena = read granted.
  - mem_wrenb = write granted.
  - mem_csen = mem_rdena | mem_wrenb.
  - Address and data are muxed from the granted client; all are zero when idle.
- Out-of-range address (≥ DATA_DEPTH):
  - The request is still granted but not forwarded to the bank (enable stays low).
  - addr_err is set.
  - A read returns data 0 with valid.
- ld_count:
  - Cleared on the RUN→LOAD transition.
  - +1 per granted loader write, including out-of-range writes.
  - Saturates at 2^ADDR_WIDTH.
- Read return:
  - A registered tag {granted client, out-of-range flag} selects the returning data.
  - The non-selected rdN_data is 0.

## Timing
- Grant latency 0 cycles; read data latency 1 cycle (rdN_valid the cycle after rdN_gnt).
- Back-to-back reads every cycle are supported; one read and one write may proceed in the same cycle.
- A read granted on the cycle load_start arrives still returns normally on the next cycle.
- Same-cycle read and write to the same address: the read returns the OLD word (bank write-after-read ordering), unless RAW_BYPASS_EN is defined.
- Reset values:
  - All gnt, valid, data and mem_* outputs are 0.
  - busy_load = 0, ld_count = 0, addr_err = 0, rr → rd0, mode = RUN.
- Reset asserted mid-operation: all state is cleared immediately; any in-flight read return is dropped (no valid).

## Configuration
- RAW_BYPASS_EN defined:
  - A same-cycle, same-address read and write registers the write data.
  - The next cycle's rdN_data returns that new word instead of mem_data_a.
  - Adds one DATA_WIDTH register and an address comparator.
- RAW_BYPASS_EN undefined: no bypass; the old word is returned.

## Test plan
- Reset, then rd0_req with addr 5 while the bank holds 0x3C at 5 → rd0_gnt in the same cycle; rd0_valid=1 and rd0_data=0x3C the next cycle; rd1_valid=0.
- rd0_req and rd1_req held high for 4 cycles → grants alternate rd0, rd1, rd0, rd1; each valid follows its grant by one cycle.
- load_start, then 3 loader writes with wb_wr_req and rd0_req also held → only ld_wr_gnt goes high; busy_load=1; ld_count=3; after load_done, wb and rd0 are granted on the following cycle.
- wb write 0xA5 to addr 7 and rd1 read of addr 7 in the same cycle (old value 0x11) → rd1_data=0x11 without the macro; 0xA5 with RAW_BYPASS_EN.
- rd0 read of addr 1024 → mem_rdena=0; rd0_valid=1 with data 0 next cycle; addr_err=1 and stays set.
- rst_n pulled low the cycle after a read grant → rd0_valid stays 0; all outputs are 0 and mode=RUN after release.
